// File: rtl/mem_loader.sv
// Byte-stream to 16-bit memory-card loader: sets the address register, assembles two bytes, strobes MI.
// Optional MEM_LOADER_CHECKSUM_EN adds a running 16-bit sum of written words on port checksum.
module mem_loader #(
  parameter int HIGH_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] word_count,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] bus_out,
  output logic        bus_en,
  output logic        AI_bar,
  output logic        MI,
  output logic        busy,
  output logic        done,
`ifdef MEM_LOADER_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic        rom_err
);

  typedef enum logic [2:0] {IDLE, SETADDR, RXB0, RXB1, WRITE, FIN} state_t;

  state_t      state_reg;
  logic [15:0] addr_reg;
  logic [15:0] remaining_reg;
  logic [7:0]  first_byte_reg;
  logic [15:0] rx_word;

  // Word as it will look once the byte currently on in_data is taken in RXB1.
  always_comb begin
    rx_word = (HIGH_FIRST != 0) ? {first_byte_reg, in_data} : {in_data, first_byte_reg};
  end

  // Outputs are registered: each transition loads the output values of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= 16'h0000;
      remaining_reg  <= 16'h0000;
      first_byte_reg <= 8'h00;
      in_ready       <= 1'b0;
      bus_out        <= 16'h0000;
      bus_en         <= 1'b0;
      AI_bar         <= 1'b1;
      MI             <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rom_err        <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      checksum       <= 16'h0000;
`endif
    end else begin
      in_ready <= 1'b0;
      bus_en   <= 1'b0;
      AI_bar   <= 1'b1;
      MI       <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b1;
      case (state_reg)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            addr_reg      <= start_addr;
            remaining_reg <= word_count;
            rom_err       <= 1'b0;
            busy          <= 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            checksum      <= 16'h0000;
`endif
            if (word_count == 16'h0000) begin
              state_reg <= FIN;
              done      <= 1'b1;
            end else begin
              state_reg <= SETADDR;
              bus_en    <= 1'b1;
              AI_bar    <= 1'b0;
              bus_out   <= start_addr;
            end
          end
        end
        SETADDR: begin
          state_reg <= RXB0;
          in_ready  <= 1'b1;
        end
        RXB0: begin
          in_ready <= 1'b1;
          if (in_valid) begin
            first_byte_reg <= in_data;
            state_reg      <= RXB1;
          end
        end
        RXB1: begin
          if (in_valid) begin
            state_reg <= WRITE;
            bus_en    <= 1'b1;
            MI        <= 1'b1;
            bus_out   <= rx_word;
            if (addr_reg < 16'h0100) rom_err <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        WRITE: begin
          addr_reg      <= addr_reg + 16'd1;
          remaining_reg <= remaining_reg - 16'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
          checksum      <= checksum + bus_out;
`endif
          if (remaining_reg == 16'd1) begin
            state_reg <= FIN;
            done      <= 1'b1;
          end else begin
            state_reg <= SETADDR;
            bus_en    <= 1'b1;
            AI_bar    <= 1'b0;
            bus_out   <= addr_reg + 16'd1;
          end
        end
        FIN: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed corner loads plus randomized loads with a stalling byte source.
module tb_mem_loader;
  localparam int HF = 1;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [15:0] start_addr, word_count;
  logic [7:0]  in_data;
  logic        in_ready, bus_en, AI_bar, MI, busy, done, rom_err;
  logic [15:0] bus_out;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  mem_loader #(.HIGH_FIRST(HF)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bus_out(bus_out), .bus_en(bus_en), .AI_bar(AI_bar),
    .MI(MI), .busy(busy), .done(done),
`ifdef MEM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .rom_err(rom_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte source: offers queued bytes with probability valid_pct, pops once accepted.
  logic [7:0] byte_q[$];
  logic [7:0] preset[$];
  int  valid_pct = 100;
  int  taken = 0;
  bit  take_pending = 0;
  always @(negedge clk) begin
    if (take_pending && byte_q.size() > 0) begin
      void'(byte_q.pop_front());
      taken++;
    end
    if (byte_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      in_valid = 1'b1;
      in_data  = byte_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    take_pending = in_valid && in_ready;
  end

  // Bus monitor: records every address load and write strobe seen.
  logic [15:0] got_a[$], got_w[$];
  int rdy_cycles = 0, clash = 0, bad_en = 0;
  always @(negedge clk) begin
    if (MI) got_w.push_back(bus_out);
    if (!AI_bar) got_a.push_back(bus_out);
    if (in_ready) rdy_cycles++;
    if (MI && !AI_bar) clash++;
    if (bus_en !== (MI || !AI_bar)) bad_en++;
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_bus_en"}, bus_en, 0);
    chk({tag, "_bus_out"}, bus_out, 0);
    chk({tag, "_AI_bar"}, AI_bar, 1);
    chk({tag, "_MI"}, MI, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rom_err"}, rom_err, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  // Starts one load and checks it end to end against a list-level model of the expected bus traffic.
  task automatic run_load(input logic [15:0] a, input int n, input int pct, input bit poke_busy);
    logic [7:0]  b[$];
    logic [15:0] exp_a[$], exp_w[$];
    logic [15:0] exp_ck;
    logic [15:0] wa;
    bit          exp_rom;
    int          lat;
    exp_ck  = 16'h0000;
    exp_rom = 1'b0;
    for (int i = 0; i < 2 * n; i++) b.push_back(preset.size() > i ? preset[i] : 8'($urandom));
    for (int i = 0; i < n; i++) begin
      wa = 16'((32'(a) + i) % 65536);
      exp_a.push_back(wa);
      exp_w.push_back(HF != 0 ? {b[2*i], b[2*i+1]} : {b[2*i+1], b[2*i]});
      exp_ck = 16'((32'(exp_ck) + 32'(exp_w[i])) % 65536);
      if (wa < 16'h0100) exp_rom = 1'b1;
    end
    @(negedge clk);
    #1;
    got_a.delete(); got_w.delete();
    rdy_cycles = 0; clash = 0; bad_en = 0;
    byte_q = b;
    valid_pct = pct;
    start = 1'b1; start_addr = a; word_count = 16'(n);
    @(negedge clk);
    start = 1'b0; start_addr = 16'($urandom); word_count = 16'($urandom);
    lat = 1;
    while (!done && lat < 2000) begin
      start = (poke_busy && lat == 3);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    #1;
    $display("load addr=0x%04h words=%0d valid_pct=%0d latency=%0d", a, n, pct, lat);
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 1);
    if (pct == 100 && !poke_busy) chk("latency", lat, (n == 0) ? 1 : 4 * n + 1);
    chk("n_addr_loads", got_a.size(), n);
    chk("n_writes", got_w.size(), n);
    for (int i = 0; i < n && i < got_a.size(); i++) chk($sformatf("setaddr_%0d", i), got_a[i], exp_a[i]);
    for (int i = 0; i < n && i < got_w.size(); i++) chk($sformatf("write_%0d", i), got_w[i], exp_w[i]);
    chk("rom_err_at_done", rom_err, exp_rom);
    chk("strobe_clash", clash, 0);
    chk("bus_en_qualify", bad_en, 0);
    chk("bytes_left", byte_q.size(), 0);
    if (n == 0) chk("in_ready_cycles", rdy_cycles, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("checksum_at_done", checksum, exp_ck);
`endif
    @(negedge clk);
    chk("busy_after_fin", busy, 0);
    chk("done_pulse_width", done, 0);
    chk("rom_err_sticky", rom_err, exp_rom);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("checksum_stable", checksum, exp_ck);
`endif
    preset.delete();
  endtask

  initial begin
    int guard;
    reset = 1'b1; start = 1'b0; start_addr = 16'h0; word_count = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    preset = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load(16'h0100, 2, 100, 1'b0);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("checksum_ref", checksum, 16'h68AC);
`endif
    run_load(16'h4000, 0, 100, 1'b0);
    run_load(16'hFFFF, 2, 100, 1'b0);
    run_load(16'h00FF, 1, 100, 1'b0);
    run_load(16'h0300, 1, 100, 1'b0);

    for (int k = 0; k < 5; k++)
      run_load(16'($urandom), $urandom_range(1, 6), $urandom_range(30, 100), k == 2);

    // Reset while the second byte of the second word is pending.
    @(negedge clk);
    got_a.delete(); got_w.delete();
    taken = 0;
    byte_q.delete();
    for (int i = 0; i < 6; i++) byte_q.push_back(8'($urandom));
    valid_pct = 50;
    start = 1'b1; start_addr = 16'h2000; word_count = 16'd3;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (taken < 3 && guard < 500) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("reset_reached_rxb1", in_ready, 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    $display("reset applied mid-word after %0d bytes, writes seen=%0d", taken, got_w.size());
    check_reset_values("midreset");
    chk("writes_before_reset", got_w.size(), 1);
    byte_q.delete();
    take_pending = 0;
    reset = 1'b0;
    run_load(16'h2000, 3, 60, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
